// File: rtl/wb_pipe_stage.sv
// wb_pipe_stage: elastic MEM->WB pipeline stage register with a valid/ready
// handshake, synchronous flush and bubble masking.
// Optional feature macro: WB_PIPE_STAGE_SKID_EN. When defined, a second skid
// entry is added and o_ready comes straight from a register. When undefined,
// there is a single head register and o_ready is combinational from i_ready.
module wb_pipe_stage #(
   parameter int unsigned        PC_W     = 32,
   parameter int unsigned        DATA_W   = 32,
   parameter int unsigned        SEL_W    = 2,
   parameter logic [DATA_W-1:0]  NOP_INST = DATA_W'(32'h0000_0013)
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [PC_W-1:0]   i_pc,
   input  logic [DATA_W-1:0] i_inst,
   input  logic [DATA_W-1:0] i_alu_data,
   input  logic [DATA_W-1:0] i_lsu_data,
   input  logic [SEL_W-1:0]  i_wb_sel,
   input  logic              i_reg_wren,
   input  logic              i_flush,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [PC_W-1:0]   o_pc,
   output logic [DATA_W-1:0] o_inst,
   output logic [DATA_W-1:0] o_alu_data,
   output logic [DATA_W-1:0] o_lsu_data,
   output logic [SEL_W-1:0]  o_wb_sel,
   output logic              o_reg_wren,
   output logic [1:0]        o_count
);

   // Payload layout (MSB..LSB): pc, inst, alu, lsu, wb_sel, reg_wren
   localparam int unsigned PAY_W   = PC_W + 3 * DATA_W + SEL_W + 1;
   localparam int unsigned WREN_LO = 0;
   localparam int unsigned SEL_LO  = WREN_LO + 1;
   localparam int unsigned LSU_LO  = SEL_LO + SEL_W;
   localparam int unsigned ALU_LO  = LSU_LO + DATA_W;
   localparam int unsigned INST_LO = ALU_LO + DATA_W;
   localparam int unsigned PC_LO   = INST_LO + DATA_W;

   logic [PAY_W-1:0] w_in_pay;
   logic [PAY_W-1:0] r_head_pay;
   logic             r_head_valid;
   logic             w_accept;
   logic             w_consume;

   assign w_in_pay  = {i_pc, i_inst, i_alu_data, i_lsu_data, i_wb_sel, i_reg_wren};
   assign w_accept  = i_valid & o_ready;
   assign w_consume = r_head_valid & i_ready;

`ifdef WB_PIPE_STAGE_SKID_EN
   logic [PAY_W-1:0] r_skid_pay;
   logic             r_skid_valid;

   assign o_ready = ~r_skid_valid;
   assign o_count = 2'({1'b0, r_head_valid}) + 2'({1'b0, r_skid_valid});

   // Head/skid update: skid refills the head first so order stays FIFO
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_head_valid <= 1'b0;
         r_head_pay   <= '0;
         r_skid_valid <= 1'b0;
         r_skid_pay   <= '0;
      end else if (i_flush) begin
         r_head_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_head_valid || w_consume) begin
         if (r_skid_valid) begin
            r_head_valid <= 1'b1;
            r_head_pay   <= r_skid_pay;
            r_skid_valid <= w_accept;
            if (w_accept) begin
               r_skid_pay <= w_in_pay;
            end
         end else if (w_accept) begin
            r_head_valid <= 1'b1;
            r_head_pay   <= w_in_pay;
         end else begin
            r_head_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid_valid <= 1'b1;
         r_skid_pay   <= w_in_pay;
      end
   end
`else
   assign o_ready = ~r_head_valid | i_ready;
   assign o_count = {1'b0, r_head_valid};

   // Single head register: flush beats accept, accept beats plain consume
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_head_valid <= 1'b0;
         r_head_pay   <= '0;
      end else if (i_flush) begin
         r_head_valid <= 1'b0;
      end else if (w_accept) begin
         r_head_valid <= 1'b1;
         r_head_pay   <= w_in_pay;
      end else if (w_consume) begin
         r_head_valid <= 1'b0;
      end
   end
`endif

   // Bubble masking: an empty stage shows a NOP and never writes back
   assign o_valid    = r_head_valid;
   assign o_pc       = r_head_valid ? r_head_pay[PC_LO   +: PC_W]   : '0;
   assign o_inst     = r_head_valid ? r_head_pay[INST_LO +: DATA_W] : NOP_INST;
   assign o_alu_data = r_head_valid ? r_head_pay[ALU_LO  +: DATA_W] : '0;
   assign o_lsu_data = r_head_valid ? r_head_pay[LSU_LO  +: DATA_W] : '0;
   assign o_wb_sel   = r_head_valid ? r_head_pay[SEL_LO  +: SEL_W]  : '0;
   assign o_reg_wren = r_head_valid & r_head_pay[WREN_LO];

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Self-checking bench for wb_pipe_stage (works with or without
// WB_PIPE_STAGE_SKID_EN defined).
module tb_wb_pipe_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_pc;
   logic [31:0] i_inst;
   logic [31:0] i_alu_data;
   logic [31:0] i_lsu_data;
   logic [1:0]  i_wb_sel;
   logic        i_reg_wren;
   logic        i_flush;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_pc;
   logic [31:0] o_inst;
   logic [31:0] o_alu_data;
   logic [31:0] o_lsu_data;
   logic [1:0]  o_wb_sel;
   logic        o_reg_wren;
   logic [1:0]  o_count;

   int n_checks = 0;
   int n_fail   = 0;

   wb_pipe_stage dut (
      .i_clk      (clk),
      .i_reset_n  (rst_n),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_pc       (i_pc),
      .i_inst     (i_inst),
      .i_alu_data (i_alu_data),
      .i_lsu_data (i_lsu_data),
      .i_wb_sel   (i_wb_sel),
      .i_reg_wren (i_reg_wren),
      .i_flush    (i_flush),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_pc       (o_pc),
      .o_inst     (o_inst),
      .o_alu_data (o_alu_data),
      .o_lsu_data (o_lsu_data),
      .o_wb_sel   (o_wb_sel),
      .o_reg_wren (o_reg_wren),
      .o_count    (o_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic        wren;
      logic        flush;
      logic        rdy;
      logic        ev;
      logic [31:0] epc;
      logic        ewren;
      logic        erdy;
      logic [1:0]  ecnt;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic        wren;
   } ent_t;

   // Data fields are derived from the PC so any mix-up is visible
   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return pc ^ 32'h5A5A_0000;
   endfunction
   function automatic logic [31:0] alu_of(input logic [31:0] pc);
      return pc + 32'h0000_1000;
   endfunction
   function automatic logic [31:0] lsu_of(input logic [31:0] pc);
      return ~pc;
   endfunction

   function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic wren,
                               input logic flush, input logic rdy, input logic ev,
                               input logic [31:0] epc, input logic ewren,
                               input logic erdy, input logic [1:0] ecnt);
      vec_t t;
      t.v = v; t.pc = pc; t.wren = wren; t.flush = flush; t.rdy = rdy;
      t.ev = ev; t.epc = epc; t.ewren = ewren; t.erdy = erdy; t.ecnt = ecnt;
      return t;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc,
                          input logic ewren);
      chk({tag, " o_valid"}, 32'(o_valid), 32'(ev));
      chk({tag, " o_pc"}, o_pc, ev ? epc : 32'h0);
      chk({tag, " o_inst"}, o_inst, ev ? inst_of(epc) : NOP);
      chk({tag, " o_alu_data"}, o_alu_data, ev ? alu_of(epc) : 32'h0);
      chk({tag, " o_lsu_data"}, o_lsu_data, ev ? lsu_of(epc) : 32'h0);
      chk({tag, " o_wb_sel"}, 32'(o_wb_sel), ev ? 32'(epc[3:2]) : 32'h0);
      chk({tag, " o_reg_wren"}, 32'(o_reg_wren), 32'(ev & ewren));
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic wren,
                        input logic flush, input logic rdy);
      i_valid    = v;
      i_pc       = pc;
      i_inst     = inst_of(pc);
      i_alu_data = alu_of(pc);
      i_lsu_data = lsu_of(pc);
      i_wb_sel   = pc[3:2];
      i_reg_wren = wren;
      i_flush    = flush;
      i_ready    = rdy;
   endtask

   // Drive one vector for a cycle and check the state just after the edge
   task automatic step(input string tag, input vec_t t);
      @(negedge clk);
      drive(t.v, t.pc, t.wren, t.flush, t.rdy);
      @(posedge clk);
      #1;
      chk_out(tag, t.ev, t.epc, t.ewren);
      chk({tag, " o_ready"}, 32'(o_ready), 32'(t.erdy));
      chk({tag, " o_count"}, 32'(o_count), 32'(t.ecnt));
   endtask

   vec_t tbl[$];
   ent_t q[$];

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

      // Reset state
      #12;
      chk_out("reset", 1'b0, 32'h0, 1'b0);
      chk("reset o_ready", 32'(o_ready), 32'h1);
      chk("reset o_count", 32'(o_count), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Mode-independent table: streaming, idle, bubble gating, flush with accept
      for (int i = 0; i < 8; i++) begin
         logic [31:0] p;
         p = 32'h100 + 32'(4 * i);
         tbl.push_back(mk(1'b1, p, 1'(i), 1'b0, 1'b1, 1'b1, p, 1'(i), 1'b1, 2'd1));
      end
      tbl.push_back(mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2'd0));
      for (int i = 0; i < 3; i++) begin
         tbl.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2'd0));
      end
      tbl.push_back(mk(1'b1, 32'h300, 1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 1'b1, 2'd1));
      tbl.push_back(mk(1'b1, 32'h304, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2'd0));
      tbl.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2'd0));
      tbl.push_back(mk(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2'd0));

      for (int i = 0; i < tbl.size(); i++) begin
         step($sformatf("vec%0d", i), tbl[i]);
      end

      // Stall sequence: 0x200 reaches head, then i_ready=0 while 0x204 is offered
      step("stall_a", mk(1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 2'd1));
`ifdef WB_PIPE_STAGE_SKID_EN
      step("stall_b", mk(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 2'd2));
      step("stall_c", mk(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 2'd2));
`else
      step("stall_b", mk(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 2'd1));
      step("stall_c", mk(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b1, 1'b0, 2'd1));
`endif
      step("stall_d", mk(1'b1, 32'h204, 1'b0, 1'b0, 1'b1, 1'b1, 32'h204, 1'b0, 1'b1, 2'd1));
      step("stall_e", mk(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 2'd0));

      // Reset asserted mid-stream drops everything at once
      step("pre_rst0", mk(1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1, 32'h400, 1'b1,
`ifdef WB_PIPE_STAGE_SKID_EN
                          1'b1,
`else
                          1'b0,
`endif
                          2'd1));
      #2;
      rst_n = 1'b0;
      #1;
      chk_out("midrst", 1'b0, 32'h0, 1'b0);
      chk("midrst o_count", 32'(o_count), 32'h0);
      @(negedge clk);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("midrst o_ready", 32'(o_ready), 32'h1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_out("postrst", 1'b0, 32'h0, 1'b0);
      chk("postrst o_ready", 32'(o_ready), 32'h1);
      chk("postrst o_count", 32'(o_count), 32'h0);

      // Random valid/ready/flush against a FIFO scoreboard
      for (int c = 0; c < 10000; c++) begin
         logic v, r, f, w, exp_rdy, acc, cons;
         logic [31:0] p;
         ent_t e;
         @(negedge clk);
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 4) < 3);
         f = ($urandom_range(0, 31) == 0);
         w = 1'($urandom_range(0, 1));
         p = 32'h1_0000 + 32'(4 * c);
         drive(v, p, w, f, r);
         #1;
`ifdef WB_PIPE_STAGE_SKID_EN
         exp_rdy = (q.size() < 2);
`else
         exp_rdy = (q.size() == 0) || r;
`endif
         if (q.size() > 0) chk_out("rnd", 1'b1, q[0].pc, q[0].wren);
         else              chk_out("rnd", 1'b0, 32'h0, 1'b0);
         chk("rnd o_ready", 32'(o_ready), 32'(exp_rdy));
         chk("rnd o_count", 32'(o_count), 32'(q.size()));
         acc  = v & exp_rdy;
         cons = (q.size() > 0) & r;
         @(posedge clk);
         if (f) begin
            q.delete();
         end else begin
            if (cons) void'(q.pop_front());
            if (acc) begin
               e.pc = p;
               e.wren = w;
               q.push_back(e);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_pipe_stage.md
# wb_pipe_stage

Parametrised, elastic pipeline stage register for the MEM→WB boundary (reusable at any stage boundary) of the pipelined RISC-V core. It carries PC, instruction, ALU result, load data, write-back select and register write-enable. It adds a valid/ready handshake, stall back-pressure, a synchronous flush, and bubble masking that the plain stage register lacks. An optional two-entry skid buffer gives full throughput with a registered `o_ready`.

## Interface
Parameters:
- `PC_W`, default 32: PC field width
- `DATA_W`, default 32: instruction, ALU and LSU data width
- `SEL_W`, default 2: write-back select width
- `NOP_INST`, default 32'h0000_0013: instruction presented while the stage is empty (addi x0,x0,0)

Ports:
- `i_clk`  in  1: clock, rising edge
- `i_reset_n`  in  1: reset, asynchronous, active-low
- `i_valid`  in  1: upstream entry valid
- `o_ready`  out  1: stage can accept an entry this cycle
- `i_pc`  in  PC_W: upstream PC
- `i_inst`  in  DATA_W: upstream instruction
- `i_alu_data`  in  DATA_W: upstream ALU result
- `i_lsu_data`  in  DATA_W: upstream load data
- `i_wb_sel`  in  SEL_W: upstream write-back select
- `i_reg_wren`  in  1: upstream register write-enable
- `i_flush`  in  1: synchronous flush; empties the stage
- `o_valid`  out  1: head entry valid
- `i_ready`  in  1: downstream accepts the head entry
- `o_pc`, `o_inst`, `o_alu_data`, `o_lsu_data`, `o_wb_sel`  out  as inputs: head entry fields
- `o_reg_wren`  out  1: head write-enable, gated by `o_valid`
- `o_count`  out  2: occupied entries, 0..2

## Operation
- Accept when `i_valid & o_ready`. Head is consumed when `o_valid & i_ready`.
- Bubble masking:
  - When `o_valid=0`: `o_inst=NOP_INST`, `o_reg_wren=0`, and `o_pc`, `o_alu_data`, `o_lsu_data` and `o_wb_sel` are 0.
  - A bubble therefore never writes the register file.
- Flush:
  - When `i_flush=1` at an edge, every entry is invalidated, `o_count` goes to 0 and `o_valid` goes to 0.
  - A same-cycle accept is discarded, so flush has priority over accept.
  - A same-cycle consume still counts as consumed downstream.
- Single-entry mode (macro off): one head register. `o_ready = ~o_valid | i_ready`, which is combinational from `i_ready`.
- Skid mode (macro on): head and skid registers.
  - `o_ready = ~skid_valid`, driven from a register.
  - Accept while the head is empty, or the head is consumed in the same cycle: the entry goes to the head. When the skid is valid and the head is consumed, the skid moves to the head and the new entry goes to the skid.
  - Accept while the head is full and not consumed: the entry goes to the skid.
  - Head consumed, skid valid, no accept: the skid moves to the head.
  - Order is strictly FIFO.
- `o_count`: 0 or 1 in single-entry mode, 0..2 in skid mode.

## Timing
- Reset, asynchronous: `o_valid=0`, `o_count=0`, all data fields 0, `o_inst=NOP_INST`, `o_reg_wren=0`.
  - `o_ready=1` from reset release; in skid mode the skid register is cleared.
  - Reset mid-transfer drops all entries with no partial outputs.
- Latency: an entry accepted at edge N appears on the outputs after edge N, in both modes.
- Throughput: one entry per cycle while `i_ready=1`, in both modes.
- Stall (`i_ready=0`) with the head full: outputs hold bit-stable.
  - Single-entry mode: `o_ready=0` in the same cycle.
  - Skid mode: one more entry is absorbed, then `o_ready=0` from the next cycle.
- Release after stall: in skid mode the skid entry reaches the head one edge after `i_ready` rises. `o_ready` returns to 1 at that same edge.
- `i_valid` and input data are sampled only on accepting edges. Inputs may change freely when not accepted.

## Configuration
- `WB_PIPE_STAGE_SKID_EN`:
  - Defined: two-entry skid buffer and registered `o_ready`, which breaks the combinational path from `i_ready` to `o_ready`. `o_count` reaches 2.
  - Undefined: single register and combinational `o_ready`. Skid logic is absent and `o_count` is never above 1.

## Test plan
- Reset and idle: assert `i_reset_n=0` mid-stream, then release. Require `o_valid=0`, `o_inst=32'h0000_0013`, `o_reg_wren=0`, `o_ready=1` and `o_count=0` immediately and after release.
- Streaming: present 8 back-to-back entries with PC 0x100, 0x104, … and `i_ready=1`. Require each to appear one cycle later, in order, with no gaps.
- Stall:
  - Present PC 0x200 then 0x204, with `i_ready=0` from the cycle 0x200 reaches the head.
  - Skid mode: require `o_count=2`, `o_ready=0`, and head held at 0x200.
  - Then raise `i_ready`: require 0x200, then 0x204, with no loss or duplication.
  - Single-entry mode: require `o_ready=0` while stalled, and 0x204 accepted only after the release.
- Flush with accept: stage holds PC 0x300, `i_valid=1` with PC 0x304, and `i_flush=1`. Require next cycle `o_valid=0`, `o_count=0`, `o_reg_wren=0`, and 0x304 never emitted.
- Bubble gating: present `i_reg_wren=1` with `i_valid=0` for 3 cycles. Require `o_reg_wren=0` and `o_inst=NOP_INST` throughout.
- Random valid/ready/flush for 10k cycles against a queue scoreboard. Require FIFO order and no drops other than flushed entries. Require `o_count` consistent with accepts minus consumes.
